laser_pulse_driver: RTL and testbench
=====================================

# laser_pulse_driver

Multi-channel laser emitter controller; parametrised successor of the single-channel always-on laser driver. Each channel runs independently in off, continuous-wave, free-running pulsed, or counted-burst mode, programmed through a shared valid/ready configuration port. It sits between the sensor sequencing logic and the laser driver pins, one `laser` output bit per emitter.

## Interface
- `CHANNELS`, 4: number of independent emitter channels (1..16).
- `CNT_W`, 16: width of the period and on-time counters.
- `BURST_W`, 8: width of the burst pulse counter.
- `MAX_ON`, 50000: watchdog limit in cycles; used only when `LASER_SAFETY_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: configuration request.
- `cfg_ready` out 1: configuration accept.
- `cfg_chan` in max(1,$clog2(CHANNELS)): target channel.
- `cfg_mode` in 2: 00 off, 01 CW, 10 pulsed, 11 burst.
- `cfg_period` in CNT_W: pulse period in cycles.
- `cfg_on` in CNT_W: high time per period in cycles.
- `cfg_count` in BURST_W: pulses per burst.
- `stop` in CHANNELS: per-channel synchronous abort.
- `laser` out CHANNELS: emitter drive, registered.
- `busy` out CHANNELS: channel is not IDLE.
- `done` out CHANNELS: one-cycle pulse at burst completion.
- `fault` out CHANNELS: sticky watchdog trip.

## Operation
- Per-channel FSM states: IDLE, CW, P_ON, P_OFF.
- **Accept rule.** A request is accepted when `cfg_valid & cfg_ready` is high at a rising edge. `cfg_ready` is 1 at every clock edge after reset release.
  - Requests with `cfg_chan >= CHANNELS` are accepted and ignored.
- **Mode 00.** Next state IDLE.
- **Mode 01.** Next state CW.
- **Modes 10 and 11.**
  - Period counter loads 0.
  - On-time is latched as min(`cfg_on`, `cfg_period`).
  - Next state is P_ON, or P_OFF if the latched on-time is 0.
  - If `cfg_period`=0, the request is treated as mode 00.
- **P_ON.** The period counter increments each cycle. The FSM goes to P_OFF when count+1 == on-time.
  - If on-time == period, it stays in P_ON and wraps the counter. This gives a constant-high output.
- **P_OFF.** The period counter increments each cycle. At count+1 == period, the pulse ends:
  - the counter clears;
  - the FSM returns to P_ON, or stays in P_OFF if on-time is 0.
- **Burst mode (11).** A remaining counter loads `cfg_count` and decrements at each pulse end.
  - When it reaches 0, the FSM goes to IDLE and `done` pulses for one cycle.
  - `cfg_count`=0 sends the FSM to IDLE immediately with a `done` pulse and no laser activity.
- **Mode 10.** Runs until reconfigured or stopped.
- **Laser output.** `laser[i]`=1 in CW, or in P_ON with a nonzero on-time; otherwise 0.
- **Busy output.** `busy[i]`=1 whenever the state is not IDLE.
- **Reconfiguring a running channel** discards the channel's phase and counters and restarts from the new configuration. No `done` is issued for the aborted burst.
- **stop[i].** Forces IDLE with no `done`. It takes priority over a simultaneous cfg to the same channel; that cfg is consumed and dropped.
- **Reset.** Asynchronous assertion forces every channel to IDLE. While `rst_n` is low:
  - `laser`, `busy`, `done`, `fault` and `cfg_ready` are all 0;
  - all counters are 0.
  - Reset mid-burst drops the burst silently.

## Timing
- **Config latency.** A request accepted at edge T updates the state at edge T. `laser` and `busy` reflect the new state in the cycle after T; this is one-cycle latency.
- **Pulsed waveform.** `laser` is high for exactly on-time cycles and low for exactly (period − on-time) cycles, with no gap between periods.
- **Burst timing.**
  - `done` is high in the cycle that follows the last P_OFF cycle, concurrent with `busy` falling.
  - For `cfg_count`=0, `done` is high in the cycle after acceptance.
- **stop timing.** `stop` sampled at edge T drives `laser` to 0 from edge T.
- **Channel independence.** Channels share no counters. Concurrent activity on other channels never alters a channel's timing.

## Configuration
- Macro `LASER_SAFETY_TIMEOUT_EN`.
- **Defined.**
  - Each channel has a ceil(log2(MAX_ON+1))-bit counter of consecutive cycles with `laser[i]`=1. The counter clears whenever `laser[i]`=0.
  - On reaching `MAX_ON`, the channel is forced to IDLE, `laser[i]` drops on the next edge, and `fault[i]` sets.
  - `fault[i]` stays set until an accepted cfg targets channel i. While `fault[i]` is set, non-off modes for that channel are ignored; the clearing cfg itself is applied normally.
- **Not defined.** `fault` is tied to 0, no watchdog logic is built, and `MAX_ON` is unused.

## Test plan
- **Reset.** Hold `rst_n`=0 for 5 cycles with `cfg_valid`=1 → `laser`=0, `busy`=0, `cfg_ready`=0. After release, `cfg_ready`=1 at the next edge.
- **Pulsed.** ch1 mode 10, period 10, on 3 → `laser[1]` repeats 3 high / 7 low starting the cycle after acceptance. Other channels stay 0.
- **Burst.** ch0 mode 11, period 4, on 2, count 3 → 3 pulses of 2 high / 2 low, then a single `done[0]` with `busy[0]` falling. A burst with count 0 → `done[0]` the cycle after acceptance, `laser[0]` never high.
- **Clamp and degenerate.** on 12 > period 8 → constant high. on 0 → constant low, `busy`=1. period 0 → channel IDLE.
- **Abort.** `stop[2]` mid-burst, together with a same-cycle cfg to ch2 → `laser[2]`=0 and `busy[2]`=0 next cycle, no `done[2]`, cfg dropped.
- **Watchdog.** With `LASER_SAFETY_TIMEOUT_EN` and `MAX_ON`=20, ch3 in CW → `laser[3]` high for 20 cycles, then 0 with `fault[3]`=1. A cfg mode 01 is then ignored; a cfg mode 00 clears `fault[3]`.

Source files
------------

// File: rtl/laser_pulse_driver.sv
// Multi-channel laser emitter controller: off / CW / pulsed / counted-burst per channel.
// Optional per-channel on-time watchdog is built when LASER_SAFETY_TIMEOUT_EN is defined.
module laser_pulse_driver #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 16,
   parameter int BURST_W  = 8,
   parameter int MAX_ON   = 50000,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_chan,
   input  logic [1:0]          cfg_mode,
   input  logic [CNT_W-1:0]    cfg_period,
   input  logic [CNT_W-1:0]    cfg_on,
   input  logic [BURST_W-1:0]  cfg_count,
   input  logic [CHANNELS-1:0] stop,
   output logic [CHANNELS-1:0] laser,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] done,
   output logic [CHANNELS-1:0] fault
);

   typedef enum logic [1:0] {S_IDLE, S_CW, S_P_ON, S_P_OFF} state_t;

   logic r_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ready <= 1'b0;
      else        r_ready <= 1'b1;
   end

   assign cfg_ready = r_ready;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      state_t             r_state;
      logic [CNT_W-1:0]   r_cnt;
      logic [CNT_W-1:0]   r_on;
      logic [CNT_W-1:0]   r_period;
      logic [BURST_W-1:0] r_rem;
      logic               r_burst;
      logic               r_laser;
      logic               r_busy;
      logic               r_done;
      logic               w_sel;
      logic               w_trip;
      logic               w_blk;
      logic               w_pend;
      logic [CNT_W-1:0]   w_cnt_inc;
      logic [CNT_W-1:0]   w_on_clamp;

      // Out-of-range channel numbers never match any g, so they are silently ignored.
      assign w_sel      = cfg_valid && r_ready && (cfg_chan == CH_W'(g));
      assign w_on_clamp = (cfg_on > cfg_period) ? cfg_period : cfg_on;
      assign w_cnt_inc  = r_cnt + CNT_W'(1);
      assign w_pend     = ((r_state == S_P_ON) && (w_cnt_inc == r_on) && (r_on == r_period)) ||
                          ((r_state == S_P_OFF) && (w_cnt_inc == r_period));

`ifdef LASER_SAFETY_TIMEOUT_EN
      localparam int WD_W = $clog2(MAX_ON + 1);
      logic [WD_W-1:0] r_wd;
      logic            r_fault;

      assign w_trip = r_laser && (r_wd == WD_W'(MAX_ON - 1));
      assign w_blk  = r_fault && (cfg_mode != 2'b00);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_wd    <= '0;
            r_fault <= 1'b0;
         end else begin
            r_wd <= (r_laser && !w_trip) ? r_wd + WD_W'(1) : '0;
            if (w_trip)
               r_fault <= 1'b1;
            else if (w_sel && !stop[g] && (cfg_mode == 2'b00))
               r_fault <= 1'b0;
         end
      end

      assign fault[g] = r_fault;
`else
      assign w_trip   = 1'b0;
      assign w_blk    = 1'b0;
      assign fault[g] = 1'b0;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_on     <= '0;
            r_period <= '0;
            r_rem    <= '0;
            r_burst  <= 1'b0;
            r_laser  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
         end else begin
            r_done <= 1'b0;
            if (w_trip || stop[g]) begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_rem   <= '0;
               r_burst <= 1'b0;
               r_laser <= 1'b0;
               r_busy  <= 1'b0;
            end else if (w_sel && !w_blk) begin
               // Any accepted request restarts the channel from phase zero.
               r_cnt    <= '0;
               r_on     <= w_on_clamp;
               r_period <= cfg_period;
               r_rem    <= cfg_count;
               r_burst  <= (cfg_mode == 2'b11);
               if (cfg_mode == 2'b01) begin
                  r_state <= S_CW;
                  r_laser <= 1'b1;
                  r_busy  <= 1'b1;
               end else if (cfg_mode[1] && (cfg_period != '0)) begin
                  if (cfg_mode[0] && (cfg_count == '0)) begin
                     r_state <= S_IDLE;
                     r_laser <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else if (w_on_clamp == '0) begin
                     r_state <= S_P_OFF;
                     r_laser <= 1'b0;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= S_P_ON;
                     r_laser <= 1'b1;
                     r_busy  <= 1'b1;
                  end
               end else begin
                  r_state <= S_IDLE;
                  r_laser <= 1'b0;
                  r_busy  <= 1'b0;
               end
            end else if ((r_state == S_P_ON) || (r_state == S_P_OFF)) begin
               if (w_pend && r_burst && (r_rem == BURST_W'(1))) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_rem   <= '0;
                  r_burst <= 1'b0;
                  r_laser <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else if (w_pend) begin
                  r_cnt <= '0;
                  if (r_burst) r_rem <= r_rem - BURST_W'(1);
                  r_state <= (r_on == '0) ? S_P_OFF : S_P_ON;
                  r_laser <= (r_on != '0);
               end else begin
                  r_cnt <= w_cnt_inc;
                  if ((r_state == S_P_ON) && (w_cnt_inc == r_on)) begin
                     r_state <= S_P_OFF;
                     r_laser <= 1'b0;
                  end
               end
            end
         end
      end

      assign laser[g] = r_laser;
      assign busy[g]  = r_busy;
      assign done[g]  = r_done;
   end

endmodule

// File: tb/tb_laser_pulse_driver.sv
// Randomized bench for laser_pulse_driver against a phase-based reference model.
// Watchdog scenarios run only when LASER_SAFETY_TIMEOUT_EN is defined.
module tb_laser_pulse_driver;
   localparam int CH = 4;
`ifdef LASER_SAFETY_TIMEOUT_EN
   localparam int MAXON = 20;
   localparam bit WD_EN = 1'b1;
`else
   localparam int MAXON = 50000;
   localparam bit WD_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [1:0]    cfg_chan = '0;
   logic [1:0]    cfg_mode = '0;
   logic [15:0]   cfg_period = '0;
   logic [15:0]   cfg_on = '0;
   logic [7:0]    cfg_count = '0;
   logic [CH-1:0] stop = '0;
   logic [CH-1:0] laser, busy, done, fault;

   int n_total = 0;
   int n_bad   = 0;

   // Model: kind 0 idle, 1 cw, 2 pulsed, 3 burst; ph = position inside the period.
   int m_kind [CH];
   int m_ph   [CH];
   int m_on   [CH];
   int m_per  [CH];
   int m_rem  [CH];
   int m_run  [CH];
   bit m_laser[CH];
   bit m_done [CH];
   bit m_fault[CH];
   bit m_ready;

   laser_pulse_driver #(.CHANNELS(CH), .CNT_W(16), .BURST_W(8), .MAX_ON(MAXON)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_on(cfg_on),
      .cfg_count(cfg_count), .stop(stop), .laser(laser), .busy(busy), .done(done), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         m_kind[i] = 0; m_ph[i] = 0; m_on[i] = 0; m_per[i] = 0; m_rem[i] = 0;
         m_run[i] = 0; m_laser[i] = 0; m_done[i] = 0; m_fault[i] = 0;
      end
      m_ready = 0;
   endtask

   task automatic model_step();
      bit acc;
      bit tripped;
      acc = cfg_valid && m_ready;
      for (int i = 0; i < CH; i++) begin
         tripped = 0;
         m_done[i] = 0;
         if (WD_EN) begin
            m_run[i] = m_laser[i] ? m_run[i] + 1 : 0;
            if (m_run[i] >= MAXON) begin
               tripped = 1; m_run[i] = 0; m_fault[i] = 1; m_kind[i] = 0;
            end
         end
         if (tripped) begin
         end else if (stop[i]) begin
            m_kind[i] = 0;
         end else if (acc && (int'(cfg_chan) == i)) begin
            if (!(m_fault[i] && cfg_mode != 2'd0)) begin
               m_fault[i] = 0;
               m_ph[i]  = 0;
               m_per[i] = cfg_period;
               m_on[i]  = (cfg_on > cfg_period) ? cfg_period : cfg_on;
               if (cfg_mode == 2'd1)                            m_kind[i] = 1;
               else if (cfg_mode == 2'd0 || cfg_period == 0)    m_kind[i] = 0;
               else if (cfg_mode == 2'd2)                       m_kind[i] = 2;
               else if (cfg_count == 0) begin m_kind[i] = 0; m_done[i] = 1; end
               else begin m_kind[i] = 3; m_rem[i] = cfg_count; end
            end
         end else if (m_kind[i] >= 2) begin
            m_ph[i]++;
            if (m_ph[i] == m_per[i]) begin
               m_ph[i] = 0;
               if (m_kind[i] == 3) begin
                  m_rem[i]--;
                  if (m_rem[i] == 0) begin m_kind[i] = 0; m_done[i] = 1; end
               end
            end
         end
         m_laser[i] = (m_kind[i] == 1) || (m_kind[i] >= 2 && m_ph[i] < m_on[i]);
      end
      m_ready = 1;
   endtask

   task automatic compare();
      logic [CH-1:0] e_l, e_b, e_d, e_f;
      for (int i = 0; i < CH; i++) begin
         e_l[i] = m_laser[i];
         e_b[i] = (m_kind[i] != 0);
         e_d[i] = m_done[i];
         e_f[i] = m_fault[i];
      end
      chk("laser", 32'(laser), 32'(e_l));
      chk("busy",  32'(busy),  32'(e_b));
      chk("done",  32'(done),  32'(e_d));
      chk("fault", 32'(fault), 32'(e_f));
      chk("ready", 32'(cfg_ready), 32'(m_ready));
   endtask

   task automatic cyc();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic send(input int ch, input int mode, input int per, input int on, input int cnt);
      cfg_valid  = 1'b1;
      cfg_chan   = 2'(ch);
      cfg_mode   = 2'(mode);
      cfg_period = 16'(per);
      cfg_on     = 16'(on);
      cfg_count  = 8'(cnt);
      cyc();
      cfg_valid  = 1'b0;
   endtask

   task automatic mid_reset(input int n);
      rst_n = 1'b0;
      model_reset();
      #1 compare();
      repeat (n) cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      // Reset held with a pending request; ready must stay low until the first edge after release.
      cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_mode = 2'd1;
      run(5);
      rst_n = 1'b1;
      cyc();
      cfg_valid = 1'b0;
      run(2);

      send(1, 2, 10, 3, 0);  run(25);
      send(1, 0, 0, 0, 0);
      send(0, 3, 4, 2, 3);   run(16);
      send(0, 3, 4, 2, 0);   run(3);
      send(2, 2, 8, 12, 0);  run(20);
      send(2, 2, 5, 0, 0);   run(12);
      send(2, 2, 0, 3, 0);   run(3);

      send(2, 3, 6, 3, 10);  run(7);
      stop = 4'b0100;
      send(2, 1, 0, 0, 0);
      stop = '0;
      run(4);

      send(0, 3, 5, 2, 4);   run(8);
      mid_reset(2);
      run(3);

      if (WD_EN) begin
         send(3, 1, 0, 0, 0); run(25);
         send(3, 1, 0, 0, 0); run(3);
         send(3, 0, 0, 0, 0); run(2);
         send(3, 2, 6, 6, 0); run(25);
         send(3, 0, 0, 0, 0); run(2);
      end

      for (int k = 0; k < 3000; k++) begin
         cfg_valid  = ($urandom_range(0, 5) == 0);
         cfg_chan   = 2'($urandom_range(0, 3));
         cfg_mode   = 2'($urandom_range(0, 3));
         cfg_period = 16'($urandom_range(0, 12));
         cfg_on     = 16'($urandom_range(0, 14));
         cfg_count  = 8'($urandom_range(0, 4));
         stop       = ($urandom_range(0, 30) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
         if (k % 700 == 699) mid_reset(2);
         else                cyc();
      end
      cfg_valid = 1'b0;
      stop = '0;
      run(5);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
